// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo up/down counter: default geometry and direction encodings.
package mod_counter_pkg;

    localparam int     DEFAULT_WIDTH   = 4;
    localparam longint DEFAULT_MODULUS = 16;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count and wrap/overflow event logic for mod_updown_counter.
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int     WIDTH   = DEFAULT_WIDTH,
    parameter longint MODULUS = DEFAULT_MODULUS
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] next_count,
    output logic             at_term,
    output logic             wrap_evt,
    output logic             ovf_evt
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic at_top;
    logic at_bot;

    assign at_top  = (count == MAX_VAL);
    assign at_bot  = (count == '0);
    assign at_term = (up_dn == DIR_UP) ? at_top : at_bot;

    // A step at the terminal value is always an overflow; it only wraps when not saturating.
    assign ovf_evt  = at_term;
    assign wrap_evt = at_term & ~sat_mode;

    always_comb begin
        next_count = count;
        if (at_term) begin
            if (!sat_mode) begin
                next_count = (up_dn == DIR_UP) ? '0 : MAX_VAL;
            end
        end else if (up_dn == DIR_UP) begin
            next_count = count + 1'b1;
        end else begin
            next_count = count - 1'b1;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with clamped load, wrap pulse and sticky overflow.
// Define MOD_UPDOWN_COUNTER_SAT_EN to add the sat_mode input (saturate instead of wrap).
module mod_updown_counter
    import mod_counter_pkg::*;
#(
    parameter int     WIDTH   = DEFAULT_WIDTH,
    parameter longint MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
    input  logic             sat_mode,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic             sat;
    logic [WIDTH-1:0] next_count;
    logic             wrap_evt;
    logic             ovf_evt;
    logic             step;
    logic [WIDTH-1:0] load_clamped;

`ifdef MOD_UPDOWN_COUNTER_SAT_EN
    assign sat = sat_mode;
`else
    assign sat = 1'b0;
`endif

    mod_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .count      (count),
        .up_dn      (up_dn),
        .sat_mode   (sat),
        .next_count (next_count),
        .at_term    (tc),
        .wrap_evt   (wrap_evt),
        .ovf_evt    (ovf_evt)
    );

    // Load has priority over counting, so a step only happens when load is low.
    assign step         = en & ~load;
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load) begin
                count <= load_clamped;
            end else if (en) begin
                count <= next_count;
            end

            wrap <= step & wrap_evt;

            if (step & ovf_evt) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (WIDTH=4, MODULUS=10) against an arithmetic model.
module tb_mod_updown_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic         clr_ovf;
    logic         sat;
    logic [W-1:0] count;
    logic         tc;
    logic         wrap;
    logic         ovf;

    int n_assert = 0;
    int n_fail   = 0;

    int m_count;
    int m_wrap;
    int m_ovf;

    mod_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .clr_ovf  (clr_ovf),
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
        .sat_mode (sat),
`endif
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model of one rising edge, written from the counting rules with plain integers.
    task automatic model_edge();
        int n;
        bit ev;
        if (load) begin
            m_count = (int'(load_val) >= M) ? M - 1 : int'(load_val);
            m_wrap  = 0;
            if (clr_ovf) m_ovf = 0;
        end else if (en) begin
            n  = m_count + (up_dn ? 1 : -1);
            ev = (n < 0) || (n >= M);
            if (ev && sat)  n = m_count;
            else            n = (n + M) % M;
            m_count = n;
            m_wrap  = (ev && !sat) ? 1 : 0;
            if (ev)           m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end else begin
            m_wrap = 0;
            if (clr_ovf) m_ovf = 0;
        end
    endtask

    task automatic check_all(input string tag);
        int exp_tc;
        exp_tc = up_dn ? int'(m_count == M - 1) : int'(m_count == 0);
        chk({tag, ".count"}, int'(count), m_count);
        chk({tag, ".tc"},    int'(tc),    exp_tc);
        chk({tag, ".wrap"},  int'(wrap),  m_wrap);
        chk({tag, ".ovf"},   int'(ovf),   m_ovf);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_val = '0; clr_ovf = 1'b0; sat = 1'b0;
        m_count = 0; m_wrap = 0; m_ovf = 0;

        #12;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Count up 12 cycles: 1..9,0,1,2 with a single wrap after 9->0.
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick("up12");
            chk("up12.seq", int'(count), (i + 1) % M);
            chk("up12.wrap_only_after_9", int'(wrap), int'(i == 9));
        end

        // Clamped load: 13 -> 9, tc high counting up, ovf unchanged.
        en = 1'b0; load = 1'b1; load_val = 4'd13;
        tick("load_clamp");
        chk("load_clamp.nine", int'(count), 9);
        chk("load_clamp.ovf_kept", int'(ovf), 1);
        load = 1'b0;

        // Wrap at 9 with clr_ovf on the same edge keeps ovf.
        en = 1'b1; up_dn = 1'b1; clr_ovf = 1'b1;
        tick("clr_vs_wrap");
        chk("clr_vs_wrap.ovf", int'(ovf), 1);

        // Down from 0 wraps to 9, then a clear with no wrap drops ovf.
        clr_ovf = 1'b0; up_dn = 1'b0;
        tick("down_wrap");
        chk("down_wrap.count", int'(count), 9);
        en = 1'b0; clr_ovf = 1'b1;
        tick("clr_ovf");
        chk("clr_ovf.ovf", int'(ovf), 0);
        clr_ovf = 1'b0;

        // Direction toggling at the boundary gives back-to-back wrap pulses.
        en = 1'b1; up_dn = 1'b1;
        tick("toggle0");
        up_dn = 1'b0; tick("toggle1");
        up_dn = 1'b1; tick("toggle2");
        chk("toggle2.wrap", int'(wrap), 1);

        // Asynchronous reset between edges, with a pending load held through an edge.
        en = 1'b0; load = 1'b1; load_val = 4'd5;
        tick("pre_rst_load");
        load = 1'b0;
        #2 rst = 1'b0;
        #1;
        m_count = 0; m_wrap = 0; m_ovf = 0;
        check_all("async_rst");
        load = 1'b1; load_val = 4'd7; en = 1'b1;
        @(posedge clk); #1;
        check_all("rst_held");
        rst = 1'b1; load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick("after_rst");
        chk("after_rst.count", int'(count), 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = $urandom_range(0, 1) == 1;
            load     = ($urandom_range(0, 9) == 0);
            load_val = W'($urandom_range(0, 15));
            clr_ovf  = ($urandom_range(0, 4) == 0);
            tick("rand");
        end

`ifdef MOD_UPDOWN_COUNTER_SAT_EN
        load = 1'b1; load_val = 4'd9; en = 1'b0; clr_ovf = 1'b1;
        tick("sat_load");
        load = 1'b0; clr_ovf = 1'b0; sat = 1'b1; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("sat_hold");
            chk("sat_hold.count", int'(count), 9);
            chk("sat_hold.ovf", int'(ovf), 1);
        end
        sat = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
